descriptor_fetch_unit: RTL
==========================

Name: descriptor_fetch_unit

Overview:
- Sits directly downstream of the system address registers (GDTR/LDTR).
- Takes a 16-bit segment selector and picks the GDT or LDT base/limit by the TI bit.
- Limit-checks the selector, then reads the 8-byte descriptor as two 32-bit memory reads.
- Decodes base, scaled limit, access byte and flags for the segment-load logic, or reports a fault with the i386 error code.

Parameters:
- ADDR_WIDTH, 32, linear address width of mem_addr and table bases.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  selector request valid.
- req_ready  out  1  unit idle, can accept a request.
- req_selector  in  16  selector: [15:3] index, [2] TI, [1:0] RPL.
- gdt_base  in  32  GDTR base.
- gdt_limit  in  16  GDTR limit (byte granular).
- ldt_base  in  32  LDTR cached base.
- ldt_limit  in  32  LDTR cached limit (already scaled).
- ldt_valid  in  1  LDTR holds a non-null descriptor.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe (ACCESSED_WRITEBACK_EN only).
- mem_addr  out  ADDR_WIDTH  dword-aligned byte address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  request completed; read data valid this cycle.
- mem_rdata  in  32  read data.
- desc_valid  out  1  result valid.
- desc_ready  in  1  consumer accepts the result.
- desc_null  out  1  selector was null (index 0, TI 0).
- desc_fault  out  1  fault (limit or LDT invalid).
- desc_error_code  out  16  {selector[15:2], 2'b00} on fault, else 0.
- desc_base  out  32  segment base.
- desc_limit  out  32  scaled segment limit.
- desc_access  out  8  access-rights byte.
- desc_flags  out  4  {G, D/B, 0, AVL}.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; FSM goes to IDLE. Reset mid-fetch abandons the fetch and drops mem_req; no partial result is ever presented.
- States: IDLE, CHECK, READ_LO, READ_HI, (WRITEBACK), DONE.
- IDLE: req_ready = 1. On req_valid, register the selector and go to CHECK.
- CHECK (one cycle), first matching rule wins:
  - Null selector (sel[15:2] == 0): go to DONE with desc_null = 1 and no memory access.
  - TI = 1 and !ldt_valid: go to DONE with fault.
  - Fault if ({index,3'b111} > limit). The comparison is 32-bit; gdt_limit is zero-extended.
  - Otherwise compute addr = table_base + {index,3'b000} mod 2^32 (wraps silently) and go to READ_LO.
- READ_LO / READ_HI:
  - mem_req = 1, mem_we = 0.
  - mem_addr = addr, then addr + 4, each held stable until mem_ack.
  - mem_rdata is captured on the mem_ack cycle.
  - The next state is entered the cycle after mem_ack.
- Decode:
  - base = {hi[31:24], hi[7:0], lo[31:16]}.
  - raw = {hi[19:16], lo[15:0]}.
  - limit = hi[23] ? {raw, 12'hFFF} : {12'h0, raw}.
  - access = hi[15:8].
  - flags = hi[23:20].
- DONE: desc_valid = 1, all outputs held stable until desc_ready; then return to IDLE. req_ready is 0 outside IDLE.
- Minimum latency with zero-wait mem_ack: request accepted T, desc_valid T+4. Null or fault: desc_valid T+2.

Optional Feature:
- Macro: ACCESSED_WRITEBACK_EN.
- Defined:
  - After READ_HI, if access[4] (S = 1) and access[0] == 0, enter WRITEBACK.
  - WRITEBACK drives mem_req = 1, mem_we = 1, mem_addr = addr + 4, mem_wdata = hi | 32'h0000_0100, held until mem_ack.
  - desc_access is then reported with bit 0 set.
  - Adds one memory cycle of latency.
- Undefined: no WRITEBACK state; mem_we and mem_wdata are tied to 0.

Test Plan:
- GDT fetch: gdt_base 0x1000, gdt_limit 0x00FF, sel 0x0008; reads return 0x0000FFFF and 0x00CF9A00 -> mem_addr 0x1008 then 0x100C; base 0, limit 0xFFFFFFFF, access 0x9A, flags 0xC, desc_valid at T+4.
- Limit fault: sel 0x0100, gdt_limit 0x00FF -> no mem_req; desc_fault = 1, error code 0x0100, desc_valid at T+2.
- Null selector: sel 0x0003 -> desc_null = 1, no mem_req. LDT with ldt_valid = 0: sel 0x000C -> fault, error code 0x000C.
- LDT fetch with wait states: ldt_base 0x2000, ldt_limit 0x0F, sel 0x000F, mem_ack delayed 3 cycles -> addresses 0x2008 and 0x200C held stable; byte-granular limit decodes correctly.
- Backpressure and reset: desc_ready held low 5 cycles -> outputs stable, req_ready = 0. Reset asserted during READ_HI -> mem_req drops asynchronously, req_ready = 1, no desc_valid.
- ACCESSED_WRITEBACK_EN: hi = 0x00CF9200 -> write to addr + 4 with data 0x00CF9300, desc_access 0x93. hi = 0x00CF9300 -> no write.

Source files
------------

// File: rtl/descriptor_fetch_unit.sv
// rtl/descriptor_fetch_unit.sv - segment descriptor fetch: selector check, two-dword read, decode
//
// Purpose: accepts a 16-bit segment selector, picks the GDT or LDT by TI,
// limit-checks the index, reads the 8-byte descriptor as two 32-bit reads and
// presents decoded base / scaled limit / access byte / flags, or a null or
// fault indication carrying the i386 error code.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready          selector request handshake; req_selector
//   gdt_base/gdt_limit           GDTR base and byte-granular limit
//   ldt_base/ldt_limit/ldt_valid LDTR cached base, scaled limit, non-null flag
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory port
//   desc_valid/desc_ready        result handshake
//   desc_null/desc_fault/desc_error_code/desc_base/desc_limit/desc_access/desc_flags
//
// Optional feature macro: ACCESSED_WRITEBACK_EN -- writes the accessed bit
// back to the descriptor high dword when a code/data descriptor is fetched
// with access[0] clear.

module descriptor_fetch_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [15:0]           req_selector,
    input  logic [31:0]           gdt_base,
    input  logic [15:0]           gdt_limit,
    input  logic [31:0]           ldt_base,
    input  logic [31:0]           ldt_limit,
    input  logic                  ldt_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic                  desc_null,
    output logic                  desc_fault,
    output logic [15:0]           desc_error_code,
    output logic [31:0]           desc_base,
    output logic [31:0]           desc_limit,
    output logic [7:0]            desc_access,
    output logic [3:0]            desc_flags
);

`ifdef ACCESSED_WRITEBACK_EN
    typedef enum logic [2:0] {
        IDLE, CHECK, READ_LO, READ_HI, WRITEBACK, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CHECK, READ_LO, READ_HI, DONE
    } state_t;
`endif

    state_t state_q, state_d;

    logic [15:0]           sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           lo_q;
    logic [31:0]           hi_q;
    logic                  null_q;
    logic                  fault_q;

    // Selector classification, evaluated against the registered selector in CHECK.
    logic        sel_ti;
    logic        sel_is_null;
    logic [31:0] table_base;
    logic [31:0] table_limit;
    logic [31:0] index_top;
    logic [31:0] table_addr;
    logic        ldt_fault;
    logic        limit_fault;
    logic [ADDR_WIDTH-1:0] addr_hi;

    assign sel_ti      = sel_q[2];
    assign sel_is_null = (sel_q[15:2] == 14'd0);
    assign table_base  = sel_ti ? ldt_base  : gdt_base;
    assign table_limit = sel_ti ? ldt_limit : {16'h0000, gdt_limit};
    // Last byte of the 8-byte descriptor must lie within the table limit.
    assign index_top   = {16'h0000, sel_q[15:3], 3'b111};
    assign table_addr  = table_base + {16'h0000, sel_q[15:3], 3'b000};
    assign ldt_fault   = sel_ti && !ldt_valid;
    assign limit_fault = (index_top > table_limit);
    assign addr_hi     = addr_q + ADDR_WIDTH'(4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = CHECK;
            end
            CHECK: begin
                if (sel_is_null || ldt_fault || limit_fault) state_d = DONE;
                else                                         state_d = READ_LO;
            end
            READ_LO: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) state_d = READ_HI;
            end
            READ_HI: begin
                mem_req  = 1'b1;
                mem_addr = addr_hi;
`ifdef ACCESSED_WRITEBACK_EN
                // S = 1 and accessed clear: the descriptor needs its A bit set.
                if (mem_ack) state_d = (mem_rdata[12] && !mem_rdata[8]) ? WRITEBACK : DONE;
`else
                if (mem_ack) state_d = DONE;
`endif
            end
`ifdef ACCESSED_WRITEBACK_EN
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_hi;
                mem_wdata = hi_q | 32'h0000_0100;
                if (mem_ack) state_d = DONE;
            end
`endif
            DONE: begin
                if (desc_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q   <= 16'h0;
            addr_q  <= '0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            null_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        sel_q   <= req_selector;
                        lo_q    <= 32'h0;
                        hi_q    <= 32'h0;
                        null_q  <= 1'b0;
                        fault_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (sel_is_null)                     null_q  <= 1'b1;
                    else if (ldt_fault || limit_fault)   fault_q <= 1'b1;
                    else                                 addr_q  <= ADDR_WIDTH'(table_addr);
                end
                READ_LO: if (mem_ack) lo_q <= mem_rdata;
                READ_HI: if (mem_ack) hi_q <= mem_rdata;
`ifdef ACCESSED_WRITEBACK_EN
                // Reflect the written accessed bit in the reported access byte.
                WRITEBACK: if (mem_ack) hi_q[8] <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Result fields are only driven while presenting, so nothing partial leaks out.
    logic [19:0] raw_limit;
    assign raw_limit = {hi_q[19:16], lo_q[15:0]};

    assign desc_valid      = (state_q == DONE);
    assign desc_null       = desc_valid && null_q;
    assign desc_fault      = desc_valid && fault_q;
    assign desc_error_code = (desc_valid && fault_q) ? (sel_q & 16'hFFFC) : 16'h0000;
    assign desc_base       = desc_valid ? {hi_q[31:24], hi_q[7:0], lo_q[31:16]} : 32'h0;
    assign desc_limit      = !desc_valid ? 32'h0 :
                             hi_q[23]    ? {raw_limit, 12'hFFF} : {12'h000, raw_limit};
    assign desc_access     = desc_valid ? hi_q[15:8]  : 8'h00;
    assign desc_flags      = desc_valid ? hi_q[23:20] : 4'h0;

endmodule
